// File: rtl/kgp_pkg.sv
// rtl/kgp_pkg.sv - KGP code constants and helpers shared by the prefix tree and the sum resolver
//
// Purpose : single definition of the 2-bit kill/propagate/generate encoding so
//           the prefix-tree generator and the back end agree on it.
// Contents: KGP_* code constants, kgp_to_carry(), kgp_local().

package kgp_pkg;

    localparam logic [1:0] KGP_KILL     = 2'b00;
    localparam logic [1:0] KGP_PROP     = 2'b01;
    localparam logic [1:0] KGP_PROP_ALT = 2'b10;
    localparam logic [1:0] KGP_GEN      = 2'b11;

    // Carry out of a bit group whose prefix status is 'code', given the
    // carry entering the least significant bit of the group. Both
    // propagate encodings pass the incoming carry through.
    function automatic logic kgp_to_carry(input logic [1:0] code, input logic cin);
        logic c;
        case (code)
            KGP_KILL: c = 1'b0;
            KGP_GEN:  c = 1'b1;
            default:  c = cin;
        endcase
        return c;
    endfunction

    // Single-bit status as produced by the leaf cells of the prefix tree:
    // {generate, generate-or-propagate}. Never yields the alternate
    // propagate code, so an incoming 10 at bit 0 is reported as inconsistent.
    function automatic logic [1:0] kgp_local(input logic a_bit, input logic b_bit);
        return {a_bit & b_bit, a_bit | b_bit};
    endfunction

endpackage

// File: rtl/kgp_carry_decode.sv
// rtl/kgp_carry_decode.sv - combinational decode of prefix KGP codes into per-bit carries
//
// Purpose : turn the prefix status of every group i..0 into the carry entering
//           bit i+1; c[0] is the external carry-in.
// Ports   : kgp [2*WIDTH-1:0] prefix codes, kgp[2i+1:2i] = status of bits i..0
//           cin               carry-in
//           c   [WIDTH:0]     carries, c[WIDTH] is the carry-out

module kgp_carry_decode
    import kgp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2*WIDTH-1:0] kgp,
    input  logic               cin,
    output logic [WIDTH:0]     c
);

    assign c[0] = cin;

    // Every prefix group starts at bit 0, so the carry into the group is
    // always cin and each carry is decoded independently of the others.
    for (genvar i = 0; i < WIDTH; i++) begin : g_carry
        assign c[i+1] = kgp_to_carry(kgp[2*i+1:2*i], cin);
    end

endmodule

// File: rtl/kgp_sum_resolver.sv
// rtl/kgp_sum_resolver.sv - two-stage back end of the pipelined KGP carry-lookahead adder
//
// Purpose : decode prefix KGP codes into carries, then produce sum, carry-out,
//           signed overflow and a bit-0 consistency flag through a two-entry
//           valid/ready pipeline.
// Ports   : clk, rst_n          clock, synchronous active-low reset
//           in_valid/in_ready  input handshake
//           a, b, cin, kgp     operands, carry-in, prefix codes (2 bits per bit)
//           out_valid/out_ready output handshake
//           sum, cout, ovf     a+b+cin mod 2^WIDTH, carry out, signed overflow
//           kgp_err            kgp[1:0] disagrees with the local code of a[0],b[0]

module kgp_sum_resolver
    import kgp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               cin,
    input  logic [2*WIDTH-1:0] kgp,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   sum,
    output logic               cout,
    output logic               ovf,
    output logic               kgp_err
);

    logic [WIDTH:0]   c_dec;

    logic             v1;
    logic [WIDTH-1:0] p1;
    logic [WIDTH:0]   c1;
    logic             err1;

    logic             v2;

    logic             s1_load;
    logic             s2_load;
    logic             s2_clear;

    kgp_carry_decode #(
        .WIDTH (WIDTH)
    ) u_carry_decode (
        .kgp (kgp),
        .cin (cin),
        .c   (c_dec)
    );

    // S1 can take a word whenever it is empty or its word moves on to S2
    // this same cycle, so a full pipeline keeps streaming at one word/cycle.
    assign in_ready = !v1 || !v2 || out_ready;
    assign s1_load  = in_valid && in_ready;
    assign s2_load  = v1 && (!v2 || out_ready);
    assign s2_clear = v2 && out_ready && !v1;

    assign out_valid = v2;

    // Stage 1 valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1 <= 1'b0;
        end else if (s1_load) begin
            v1 <= 1'b1;
        end else if (s2_load) begin
            v1 <= 1'b0;
        end
    end

    // Stage 1 payload: only meaningful while v1 is set, so no reset needed
    always_ff @(posedge clk) begin
        if (s1_load) begin
            p1   <= a ^ b;
            c1   <= c_dec;
            err1 <= (kgp[1:0] != kgp_local(a[0], b[0]));
        end
    end

    // Stage 2: output registers, cleared on reset and held while stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2      <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            kgp_err <= 1'b0;
        end else if (s2_load) begin
            v2      <= 1'b1;
            sum     <= p1 ^ c1[WIDTH-1:0];
            cout    <= c1[WIDTH];
            // Signed overflow: carry into the sign bit differs from carry out
            ovf     <= c1[WIDTH] ^ c1[WIDTH-1];
            kgp_err <= err1;
        end else if (s2_clear) begin
            v2      <= 1'b0;
        end
    end

endmodule
